// File: rtl/ds18b20_reader.sv
// DS18B20 1-Wire master: continuous reset/convert/read loop, 12-bit result to sign/int/hundredths.
// Define CRC8_CHECK_EN to read the full 9-byte scratchpad and discard reads failing CRC-8.
module ds18b20_reader #(
  parameter int CNT_1US        = 50,
  parameter int CONV_WAIT_US   = 750000,
  parameter int PRES_SAMPLE_US = 70
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  inout  logic       dq,
  output logic [7:0] temp_int,
  output logic [7:0] temp_deci,
  output logic       temp_sign,
  output logic       temp_valid,
  output logic       sensor_err
);

  localparam int TICK_W = (CNT_1US > 1) ? $clog2(CNT_1US) : 1;
  localparam int MAX_US = (CONV_WAIT_US > 500) ? CONV_WAIT_US : 500;
  localparam int US_W   = $clog2(MAX_US + 1);
`ifdef CRC8_CHECK_EN
  localparam int RD_BITS = 72;
`else
  localparam int RD_BITS = 16;
`endif
  localparam int BIT_W = $clog2(RD_BITS);

  localparam logic [US_W-1:0] US_RST_END  = US_W'(499);
  localparam logic [US_W-1:0] US_PRES     = US_W'(PRES_SAMPLE_US);
  localparam logic [US_W-1:0] US_CONV_END = US_W'(CONV_WAIT_US - 1);
  localparam logic [US_W-1:0] US_SLOT_END = US_W'(64);
  localparam logic [US_W-1:0] US_RD_SMP   = US_W'(12);
  localparam logic [US_W-1:0] US_INIT_LOW = US_W'(2);
  localparam logic [US_W-1:0] US_ZERO_LOW = US_W'(60);

  // Hundredths for each 1/16 degC step, truncated.
  localparam logic [7:0] DECI_LUT [16] = '{
    8'd0,  8'd6,  8'd12, 8'd18, 8'd25, 8'd31, 8'd37, 8'd43,
    8'd50, 8'd56, 8'd62, 8'd68, 8'd75, 8'd81, 8'd87, 8'd93
  };

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_REL,
    ST_WR_CMD,
    ST_CONV_WAIT,
    ST_RD_DATA,
    ST_UPDATE
  } state_t;

  state_t              state_q,      state_d;
  logic [TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
  logic [US_W-1:0]     us_cnt_q,     us_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic                byte_cnt_q,   byte_cnt_d;
  logic                round_q,      round_d;
  logic                present_q,    present_d;
  logic [15:0]         raw_q,        raw_d;
  logic                dq_oe_q,      dq_oe_d;
  logic                dq_s1_q,      dq_s2_q;
  logic [7:0]          temp_int_q,   temp_int_d;
  logic [7:0]          temp_deci_q,  temp_deci_d;
  logic                temp_sign_q,  temp_sign_d;
  logic                temp_valid_q, temp_valid_d;
  logic                sensor_err_q, sensor_err_d;
`ifdef CRC8_CHECK_EN
  logic [7:0]          crc_q,        crc_d;
  logic [7:0]          crc_rx_q,     crc_rx_d;
`endif

  logic        tick;
  logic [7:0]  cmd_byte;
  logic        cmd_bit;
  logic [11:0] mag;
  logic        read_ok;
  logic        unused_raw;

  assign dq = dq_oe_q ? 1'b0 : 1'bz;

  assign temp_int   = temp_int_q;
  assign temp_deci  = temp_deci_q;
  assign temp_sign  = temp_sign_q;
  assign temp_valid = temp_valid_q;
  assign sensor_err = sensor_err_q;

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(CNT_1US - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    state_d      = state_q;
    us_cnt_d     = us_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    round_d      = round_q;
    present_d    = present_q;
    raw_d        = raw_q;
    dq_oe_d      = 1'b0;
    temp_int_d   = temp_int_q;
    temp_deci_d  = temp_deci_q;
    temp_sign_d  = temp_sign_q;
    temp_valid_d = 1'b0;
    sensor_err_d = sensor_err_q;
`ifdef CRC8_CHECK_EN
    crc_d        = crc_q;
    crc_rx_d     = crc_rx_q;
    read_ok      = (crc_q == crc_rx_q);
`else
    read_ok      = 1'b1;
`endif

    cmd_byte   = !byte_cnt_q ? 8'hCC : (round_q ? 8'hBE : 8'h44);
    cmd_bit    = cmd_byte[bit_cnt_q[2:0]];
    // Low 12 bits of the 16-bit two's-complement magnitude; the upper bits are sign extension.
    mag        = raw_q[15] ? (~raw_q[11:0] + 12'd1) : raw_q[11:0];
    unused_raw = ^raw_q[14:12];

    case (state_q)
      ST_RST_LOW: begin
        dq_oe_d = 1'b1;
        if (tick) begin
          us_cnt_d = us_cnt_q + 1'b1;
          if (us_cnt_q == US_RST_END) begin
            us_cnt_d  = '0;
            present_d = 1'b0;
            state_d   = ST_RST_REL;
          end
        end
      end

      ST_RST_REL: begin
        if (tick) begin
          us_cnt_d = us_cnt_q + 1'b1;
          if (us_cnt_q == US_PRES) present_d = ~dq_s2_q;
          if (us_cnt_q == US_RST_END) begin
            us_cnt_d = '0;
            if (present_q) begin
              sensor_err_d = 1'b0;
              bit_cnt_d    = '0;
              byte_cnt_d   = 1'b0;
              state_d      = ST_WR_CMD;
            end else begin
              sensor_err_d = 1'b1;
              state_d      = ST_RST_LOW;
            end
          end
        end
      end

      ST_WR_CMD: begin
        dq_oe_d = (us_cnt_q < US_INIT_LOW) || (!cmd_bit && (us_cnt_q < US_ZERO_LOW));
        if (tick) begin
          us_cnt_d = us_cnt_q + 1'b1;
          if (us_cnt_q == US_SLOT_END) begin
            us_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              bit_cnt_d  = '0;
              byte_cnt_d = ~byte_cnt_q;
              if (byte_cnt_q) begin
`ifdef CRC8_CHECK_EN
                crc_d   = '0;
`endif
                state_d = round_q ? ST_RD_DATA : ST_CONV_WAIT;
              end
            end
          end
        end
      end

      ST_CONV_WAIT: begin
        if (tick) begin
          us_cnt_d = us_cnt_q + 1'b1;
          if (us_cnt_q == US_CONV_END) begin
            us_cnt_d = '0;
            round_d  = 1'b1;
            state_d  = ST_RST_LOW;
          end
        end
      end

      ST_RD_DATA: begin
        dq_oe_d = (us_cnt_q < US_INIT_LOW);
        if (tick) begin
          us_cnt_d = us_cnt_q + 1'b1;
          if (us_cnt_q == US_RD_SMP) begin
`ifdef CRC8_CHECK_EN
            // Temperature word is bytes 0-1; CRC covers bytes 0-7 and byte 8 is the received CRC.
            if (bit_cnt_q < BIT_W'(16)) raw_d = {dq_s2_q, raw_q[15:1]};
            if (bit_cnt_q < BIT_W'(64))
              crc_d = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ dq_s2_q) ? 8'h8C : 8'h00);
            else
              crc_rx_d = {dq_s2_q, crc_rx_q[7:1]};
`else
            raw_d = {dq_s2_q, raw_q[15:1]};
`endif
          end
          if (us_cnt_q == US_SLOT_END) begin
            us_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(RD_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = ST_UPDATE;
            end
          end
        end
      end

      ST_UPDATE: begin
        if (read_ok) begin
          temp_sign_d  = raw_q[15];
          temp_int_d   = mag[11:4];
          temp_deci_d  = DECI_LUT[mag[3:0]];
          temp_valid_d = 1'b1;
        end
        us_cnt_d = '0;
        round_d  = 1'b0;
        state_d  = ST_RST_LOW;
      end

      default: begin
        us_cnt_d = '0;
        round_d  = 1'b0;
        state_d  = ST_RST_LOW;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_RST_LOW;
      tick_cnt_q   <= '0;
      us_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= 1'b0;
      round_q      <= 1'b0;
      present_q    <= 1'b0;
      raw_q        <= '0;
      dq_oe_q      <= 1'b0;
      dq_s1_q      <= 1'b1;
      dq_s2_q      <= 1'b1;
      temp_int_q   <= '0;
      temp_deci_q  <= '0;
      temp_sign_q  <= 1'b0;
      temp_valid_q <= 1'b0;
      sensor_err_q <= 1'b0;
`ifdef CRC8_CHECK_EN
      crc_q        <= '0;
      crc_rx_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      us_cnt_q     <= us_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      round_q      <= round_d;
      present_q    <= present_d;
      raw_q        <= raw_d;
      dq_oe_q      <= dq_oe_d;
      dq_s1_q      <= dq;
      dq_s2_q      <= dq_s1_q;
      temp_int_q   <= temp_int_d;
      temp_deci_q  <= temp_deci_d;
      temp_sign_q  <= temp_sign_d;
      temp_valid_q <= temp_valid_d;
      sensor_err_q <= sensor_err_d;
`ifdef CRC8_CHECK_EN
      crc_q        <= crc_d;
      crc_rx_q     <= crc_rx_d;
`endif
    end
  end

endmodule

// File: doc/ds18b20_reader.md
Name: ds18b20_reader

Overview:
- Master for a DS18B20 1-Wire temperature sensor. Runs continuous convert/read cycles and converts the 12-bit result to the sign/integer/hundredths values consumed by the 7-segment scanner (temp_int, temp_deci).
- Sits directly upstream of the dynamic display stage.
- Drives the open-drain DQ pin. An external pull-up is required.

Parameters:
- CNT_1US, 50, sys_clk cycles per 1 us tick (50 MHz).
- CONV_WAIT_US, 750000, microseconds to wait after Convert T. The bench overrides this to a small value.
- PRES_SAMPLE_US, 70, microseconds after reset release at which DQ is sampled for presence.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- dq  inout  1  1-Wire bus. Driven only to 0 or high-Z.
- temp_int  output  8  integer part of the magnitude, degC
- temp_deci  output  8  fraction of the magnitude in hundredths, 0..93
- temp_sign  output  1  1 = negative temperature
- temp_valid  output  1  one-cycle pulse when the outputs update
- sensor_err  output  1  1 = last reset saw no presence pulse

Behaviour:
- Interface: clock sys_clk; reset sys_rst_n, asynchronous, active-low.
- Reset values: temp_int 0, temp_deci 0, temp_sign 0, temp_valid 0, sensor_err 0; DQ released (Z); FSM in ST_RST_LOW; all counters 0.
- Timebase: a 1 us tick from a counter wrapping at CNT_1US-1. All bus timing is counted in us ticks.
- FSM states:
  - ST_RST_LOW: drive DQ=0 for 500 us.
  - ST_RST_REL: release DQ. Sample DQ at PRES_SAMPLE_US; 0 = present. Stay until 500 us have elapsed since release.
    - Present: clear sensor_err, go to ST_WR_CMD.
    - Absent: set sensor_err, go to ST_RST_LOW. No output update.
  - ST_WR_CMD: send 2 bytes, LSB first, one 65 us slot per bit.
    - Slot: drive 0 for 0..1 us.
    - Bit=1: release at 2 us. Bit=0: hold 0 until 60 us, then release.
    - Round 0 bytes: 0xCC, 0x44, then go to ST_CONV_WAIT.
    - Round 1 bytes: 0xCC, 0xBE, then go to ST_RD_DATA.
  - ST_CONV_WAIT: DQ released for CONV_WAIT_US, then set round=1 and go to ST_RST_LOW.
  - ST_RD_DATA: read 16 bits, LSB first, 65 us slots.
    - Slot: drive 0 for 0..1 us, release, sample DQ at 12 us, shift into raw[15:0].
    - Then go to ST_UPDATE.
  - ST_UPDATE: one cycle.
    - Register the outputs and pulse temp_valid.
    - Set round=0 and go to ST_RST_LOW. The loop repeats forever.
- Arithmetic:
  - temp_sign = raw[15].
  - mag = raw[15] ? (~raw + 1) : raw, 16 bits.
  - temp_int = mag[11:4].
  - temp_deci = (mag[3:0] * 625) / 100, truncated. Examples: 0→0, 1→6, 2→12, 8→50, 15→93.
- All outputs hold between updates. temp_valid is high for exactly one sys_clk cycle per completed read.
- DQ input is synchronized with two flops before sampling.
- Reset asserted mid-operation (any state, including mid-slot):
  - DQ is released asynchronously.
  - Outputs return to reset values.
  - After deassertion the sequence restarts with round 0 and a fresh 500 us reset pulse.
- Bit-slot and byte counters wrap to 0 at the end of each byte/word. There is no partial-byte carry between states.

Optional Feature:
- Macro CRC8_CHECK_EN.
- Defined:
  - ST_RD_DATA reads all 9 scratchpad bytes (72 bits).
  - A CRC-8 (poly x^8+x^5+x^4+1, init 0, LSB first) is computed over bytes 0..7 and compared with byte 8.
  - Match: update as normal.
  - Mismatch: no output update, no temp_valid; go to ST_RST_LOW with round=0.
- Not defined: only 16 bits are read; no check is performed.

Test Plan:
1. Sensor model returns raw 0x0191 (CONV_WAIT_US=100) -> temp_int=25, temp_deci=6, temp_sign=0, single temp_valid pulse, sensor_err=0.
2. Raw 0xFF5E -> temp_sign=1, temp_int=10, temp_deci=12.
3. Raw 0x07D0 -> temp_int=125, temp_deci=0, temp_sign=0. Raw 0x0000 -> all zero with valid pulse.
4. No presence pulse -> sensor_err=1 after the first reset sequence, no temp_valid, outputs unchanged. Then attach the sensor -> sensor_err=0 and next valid with correct value.
5. Assert sys_rst_n low at bit 5 of the read -> DQ=Z immediately, outputs zero. After release, DQ goes low for 500 us (±1 us), and the round-0 commands 0xCC, 0x44 are observed on the bus.
6. With CRC8_CHECK_EN, model sends a corrupted CRC byte -> no temp_valid, outputs hold the previous value. The same stimulus without the macro -> outputs update.
